// File: rtl/fighter_fsm_param.sv
// Per-fighter walk / attack / stun state machine, advanced only on frame_en strobes.
// Define INPUT_BUFFER_EN to buffer an attack pressed near the end of recovery.
module fighter_fsm_param #(
  parameter int ATK_START        = 5,
  parameter int ATK_ACTIVE       = 2,
  parameter int ATK_RECOVERY     = 16,
  parameter int DIR_START        = 4,
  parameter int DIR_ACTIVE       = 3,
  parameter int DIR_RECOVERY     = 15,
  parameter int HITSTUN_OFFSET   = 1,
  parameter int BLOCKSTUN_OFFSET = 3,
  parameter int CNT_W            = 6,
  parameter int BUFFER_FRAMES    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_en,
  input  logic             left,
  input  logic             right,
  input  logic             attack,
  input  logic             got_hit,
  input  logic             got_blocked,
  input  logic             hit_by_diratk,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] frame_count,
  output logic             move_flag,
  output logic             attack_flag,
  output logic             directional_attack_flag,
  output logic             hitbox_active,
  output logic             stun_flag
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_BACK      = 4'd1,
    S_FWD       = 4'd2,
    S_ATK_S     = 4'd3,
    S_ATK_A     = 4'd4,
    S_ATK_R     = 4'd5,
    S_DIR_S     = 4'd6,
    S_DIR_A     = 4'd7,
    S_DIR_R     = 4'd8,
    S_HITSTUN   = 4'd9,
    S_BLOCKSTUN = 4'd10
  } state_t;

  // Phase lengths are stored as "last frame index" (len-1) so they fit in CNT_W bits.
  localparam logic [CNT_W-1:0] L_ATK_S   = CNT_W'(ATK_START - 1);
  localparam logic [CNT_W-1:0] L_ATK_A   = CNT_W'(ATK_ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_ATK_R   = CNT_W'(ATK_RECOVERY - 1);
  localparam logic [CNT_W-1:0] L_DIR_S   = CNT_W'(DIR_START - 1);
  localparam logic [CNT_W-1:0] L_DIR_A   = CNT_W'(DIR_ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_DIR_R   = CNT_W'(DIR_RECOVERY - 1);
  localparam logic [CNT_W-1:0] L_HIT_ATK = CNT_W'(ATK_RECOVERY - HITSTUN_OFFSET - 1);
  localparam logic [CNT_W-1:0] L_HIT_DIR = CNT_W'(DIR_RECOVERY - HITSTUN_OFFSET - 1);
  localparam logic [CNT_W-1:0] L_BLK_ATK = CNT_W'(ATK_RECOVERY - BLOCKSTUN_OFFSET - 1);
  localparam logic [CNT_W-1:0] L_BLK_DIR = CNT_W'(DIR_RECOVERY - BLOCKSTUN_OFFSET - 1);

  if (ATK_START < 1 || ATK_ACTIVE < 1 || ATK_RECOVERY < 1 ||
      DIR_START < 1 || DIR_ACTIVE < 1 || DIR_RECOVERY < 1 || BUFFER_FRAMES < 1 ||
      ATK_RECOVERY - BLOCKSTUN_OFFSET < 1 || DIR_RECOVERY - BLOCKSTUN_OFFSET < 1 ||
      ATK_RECOVERY - HITSTUN_OFFSET < 1 || DIR_RECOVERY - HITSTUN_OFFSET < 1 ||
      ATK_START > 2**CNT_W || ATK_ACTIVE > 2**CNT_W || ATK_RECOVERY > 2**CNT_W ||
      DIR_START > 2**CNT_W || DIR_ACTIVE > 2**CNT_W || DIR_RECOVERY > 2**CNT_W) begin : g_cfg_error
    $error("fighter_fsm_param: phase length outside 1..2**CNT_W");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_frame_count;
  logic [CNT_W-1:0] r_stun_last;
  logic             r_pend_hit;
  logic             r_pend_blk;
  logic             r_pend_dir;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_fc;
  logic [CNT_W-1:0] w_next_stun_last;
  logic [CNT_W-1:0] w_last;
  logic             w_hit;
  logic             w_blk;
  logic             w_dir;

`ifdef INPUT_BUFFER_EN
  localparam logic [CNT_W-1:0] BUF_TH_ATK =
    (ATK_RECOVERY > BUFFER_FRAMES) ? CNT_W'(ATK_RECOVERY - BUFFER_FRAMES) : '0;
  localparam logic [CNT_W-1:0] BUF_TH_DIR =
    (DIR_RECOVERY > BUFFER_FRAMES) ? CNT_W'(DIR_RECOVERY - BUFFER_FRAMES) : '0;

  logic r_buf_valid;
  logic r_buf_dir;
  logic w_buf_valid_next;
  logic w_buf_dir_next;
`endif

  // Events on the strobe cycle itself are merged with those latched since the last strobe;
  // a hit in the same cycle as a block drops the block.
  assign w_hit = r_pend_hit | got_hit;
  assign w_blk = r_pend_blk | (got_blocked & ~got_hit);
  assign w_dir = (got_hit | got_blocked) ? hit_by_diratk : r_pend_dir;

  always_comb begin
    case (r_state)
      S_ATK_S:                w_last = L_ATK_S;
      S_ATK_A:                w_last = L_ATK_A;
      S_ATK_R:                w_last = L_ATK_R;
      S_DIR_S:                w_last = L_DIR_S;
      S_DIR_A:                w_last = L_DIR_A;
      S_DIR_R:                w_last = L_DIR_R;
      S_HITSTUN, S_BLOCKSTUN: w_last = r_stun_last;
      default:                w_last = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_next_state     = r_state;
    w_next_fc        = r_frame_count;
    w_next_stun_last = r_stun_last;
`ifdef INPUT_BUFFER_EN
    w_buf_valid_next = r_buf_valid & ~w_blk;
    w_buf_dir_next   = r_buf_dir;
`endif
    if (w_hit) begin
      w_next_state     = S_HITSTUN;
      w_next_fc        = '0;
      w_next_stun_last = w_dir ? L_HIT_DIR : L_HIT_ATK;
`ifdef INPUT_BUFFER_EN
      w_buf_valid_next = 1'b0;
`endif
    end else if (w_blk && (r_state == S_IDLE || r_state == S_BACK ||
                           r_state == S_FWD  || r_state == S_BLOCKSTUN)) begin
      w_next_state     = S_BLOCKSTUN;
      w_next_fc        = '0;
      w_next_stun_last = w_dir ? L_BLK_DIR : L_BLK_ATK;
    end else if (r_state == S_IDLE || r_state == S_BACK || r_state == S_FWD) begin
      if ((left ^ right) & attack)      w_next_state = S_DIR_S;
      else if (attack & ~left & ~right) w_next_state = S_ATK_S;
      else if (left & ~right)           w_next_state = S_BACK;
      else if (right & ~left)           w_next_state = S_FWD;
      else                              w_next_state = S_IDLE;
      // Free-running states count frames spent, saturating instead of wrapping.
      if (w_next_state != r_state)  w_next_fc = '0;
      else if (!(&r_frame_count))   w_next_fc = r_frame_count + 1'b1;
    end else begin
`ifdef INPUT_BUFFER_EN
      if (attack && !w_blk &&
          ((r_state == S_ATK_R && r_frame_count >= BUF_TH_ATK) ||
           (r_state == S_DIR_R && r_frame_count >= BUF_TH_DIR))) begin
        w_buf_valid_next = 1'b1;
        w_buf_dir_next   = left ^ right;
      end
`endif
      if (r_frame_count >= w_last) begin
        w_next_fc = '0;
        case (r_state)
          S_ATK_S: w_next_state = S_ATK_A;
          S_ATK_A: w_next_state = S_ATK_R;
          S_DIR_S: w_next_state = S_DIR_A;
          S_DIR_A: w_next_state = S_DIR_R;
          default: w_next_state = S_IDLE;
        endcase
`ifdef INPUT_BUFFER_EN
        if ((r_state == S_ATK_R || r_state == S_DIR_R) && w_buf_valid_next) begin
          w_next_state     = w_buf_dir_next ? S_DIR_S : S_ATK_S;
          w_buf_valid_next = 1'b0;
        end
`endif
      end else begin
        w_next_fc = r_frame_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      r_state       <= S_IDLE;
      r_frame_count <= '0;
      r_stun_last   <= '0;
      r_pend_hit    <= 1'b0;
      r_pend_blk    <= 1'b0;
      r_pend_dir    <= 1'b0;
`ifdef INPUT_BUFFER_EN
      r_buf_valid   <= 1'b0;
      r_buf_dir     <= 1'b0;
`endif
    end else if (frame_en) begin
      r_state       <= w_next_state;
      r_frame_count <= w_next_fc;
      r_stun_last   <= w_next_stun_last;
      r_pend_hit    <= 1'b0;
      r_pend_blk    <= 1'b0;
      r_pend_dir    <= 1'b0;
`ifdef INPUT_BUFFER_EN
      r_buf_valid   <= w_buf_valid_next;
      r_buf_dir     <= w_buf_dir_next;
`endif
    end else begin
      if (got_hit)                 r_pend_hit <= 1'b1;
      if (got_blocked & ~got_hit)  r_pend_blk <= 1'b1;
      if (got_hit | got_blocked)   r_pend_dir <= hit_by_diratk;
    end
  end

  assign state                   = r_state;
  assign frame_count             = r_frame_count;
  assign move_flag               = (r_state == S_BACK)  || (r_state == S_FWD);
  assign attack_flag             = (r_state == S_ATK_S) || (r_state == S_ATK_A) ||
                                   (r_state == S_DIR_S) || (r_state == S_DIR_A);
  assign directional_attack_flag = (r_state == S_DIR_S) || (r_state == S_DIR_A);
  assign hitbox_active           = (r_state == S_ATK_A) || (r_state == S_DIR_A);
  assign stun_flag               = (r_state == S_HITSTUN) || (r_state == S_BLOCKSTUN);

endmodule

// File: doc/fighter_fsm_param.md
# fighter_fsm_param

Parametrised per-fighter move/stun state machine for the hit-and-block game core. Tracks walk, normal attack, directional attack, hitstun and blockstun.
- Advances only on a frame-enable strobe, so it runs from the system clock.
- Move and stun frame counts are parameters.
- Stun length depends on the attacker's move type.
- Hits can interrupt startup and recovery.
- Optionally buffers an attack pressed near the end of recovery.
- Sits between the input debouncer and the sprite renderer / hit-detection logic.

## Interface
Parameters:
- ATK_START = 5, ATK_ACTIVE = 2, ATK_RECOVERY = 16: normal attack phase lengths, in frames.
- DIR_START = 4, DIR_ACTIVE = 3, DIR_RECOVERY = 15: directional attack phase lengths, in frames.
- HITSTUN_OFFSET = 1, BLOCKSTUN_OFFSET = 3: frames subtracted from the attacker's recovery to get the stun length.
- CNT_W = 6: frame counter width. Every phase length must be ≤ 2^CNT_W, and every length must be ≥ 1.
- BUFFER_FRAMES = 4: size of the buffer window at the end of recovery (used only with INPUT_BUFFER_EN).

Ports (clock and reset first):
- clk  in  1: system clock. One clock; all logic is on the rising edge.
- reset  in  1: synchronous, active-high reset.
- frame_en  in  1: one-cycle frame strobe. All state and counter advancement happens only on cycles where frame_en=1.
- left, right, attack  in  1 each: player inputs, level-sampled on frame_en cycles.
- got_hit, got_blocked  in  1 each: contact event pulses; may arrive on any cycle.
- hit_by_diratk  in  1: attacker move type, qualifies got_hit/got_blocked on the same cycle (1 = directional attack).
- state  out  4: current state. Encoding: IDLE 0, BACK 1, FWD 2, ATK_S 3, ATK_A 4, ATK_R 5, DIR_S 6, DIR_A 7, DIR_R 8, HITSTUN 9, BLOCKSTUN 10.
- frame_count  out  CNT_W: frames elapsed in the current state.
- move_flag  out  1: 1 in BACK/FWD.
- attack_flag  out  1: 1 in ATK_S/ATK_A/DIR_S/DIR_A.
- directional_attack_flag  out  1: 1 in DIR_S/DIR_A.
- hitbox_active  out  1: 1 in ATK_A/DIR_A.
- stun_flag  out  1: 1 in HITSTUN/BLOCKSTUN.

## Operation
Reset: all outputs and internal registers clear to 0 (state=IDLE). Reset overrides frame_en and pending events, including mid-attack or mid-stun.

Pending events:
- got_hit / got_blocked arriving between strobes set pend_hit / pend_blk and latch hit_by_diratk into pend_dir.
- On the next frame_en cycle these are consumed and cleared.
- An event on the frame_en cycle itself is acted on directly.
- A later pulse before the strobe overwrites pend_dir.

On each frame_en cycle, evaluated in priority order:
1. pend_hit, in any state (including HITSTUN, which gives a combo reset): go to HITSTUN, frame_count=0, stun_len = (pend_dir ? DIR_RECOVERY : ATK_RECOVERY) − HITSTUN_OFFSET. Clears the buffer.
2. pend_blk, in IDLE/BACK/FWD/BLOCKSTUN only: go to BLOCKSTUN with stun_len = recovery − BLOCKSTUN_OFFSET. A block event in attack states is discarded.
3. From IDLE/BACK/FWD, on the inputs:
   - (left^right) & attack → DIR_S.
   - attack & ~left & ~right → ATK_S.
   - left & ~right → BACK.
   - right & ~left → FWD.
   - otherwise → IDLE.
4. Timed states (ATK_*, DIR_*, stun): if frame_count ≥ len−1, advance and clear frame_count; otherwise increment frame_count.
   - Phase order: S→A→R→IDLE.
   - Stun states → IDLE.

stun_len is latched on entry into the stun state and is not affected by later hit_by_diratk changes.

## Timing
- Registered transitions: the state changes on the clk edge of the deciding frame_en cycle. Outputs are decoded combinationally from the registered state.
- A timed state entered on strobe k is held for exactly len strobes and exits on strobe k+len.
- Default lengths:
  - Normal attack: 5+2+16 = 23 strobes.
  - Directional attack: 4+3+15 = 22 strobes.
  - Hitstun: 15 strobes (14 when hit_by_diratk=1).
  - Blockstun: 13 strobes (12 when hit_by_diratk=1).
- Without frame_en, nothing changes except the pending-event latches.
- got_hit and got_blocked in the same cycle: the hit wins, and the block is dropped.

## Configuration
INPUT_BUFFER_EN:
- Defined:
  - In ATK_R/DIR_R, a frame_en cycle with attack=1 and frame_count ≥ len−BUFFER_FRAMES sets buf_valid and buf_dir = left^right. The last press in the window wins.
  - On recovery exit with buf_valid, the next state is DIR_S (buf_dir=1) or ATK_S instead of IDLE, and buf_valid clears.
  - Hit, block and reset clear buf_valid.
- Undefined: no buffer registers; recovery always exits to IDLE and attack is ignored outside IDLE/BACK/FWD.

## Test plan
- frame_en=1 every cycle, attack pulse in IDLE → state 3 ×5, 4 ×2 (hitbox_active=1), 5 ×16, then 0.
- got_hit with hit_by_diratk=0 in IDLE → HITSTUN for 15 strobes, stun_flag=1, then IDLE. Repeat with hit_by_diratk=1 → 14 strobes.
- frame_en every 4th cycle, got_hit pulse 2 cycles before a strobe → HITSTUN entered on that strobe; timed durations ×4 in cycles.
- got_hit during ATK_S frame 2 → HITSTUN immediately, attack_flag drops. got_blocked during ATK_A → ignored, attack completes in 23 strobes.
- With INPUT_BUFFER_EN: hold right+attack at ATK_R frame_count=13 → state goes 5→6 with no IDLE strobe. Attack at frame_count=11 → not buffered, exits to 0.
- reset asserted mid-DIR_A → next cycle state=0, frame_count=0, all flags 0.
